// File: rtl/keypad_hex_entry.sv
// rtl/keypad_hex_entry.sv - keypad debounce, key strobe and multi-digit hex entry register
// Optional auto-repeat while a key is held: define KEYPAD_HEX_ENTRY_AUTOREPEAT_EN.
module keypad_hex_entry #(
  parameter int DIGITS          = 4,
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int REPEAT_DELAY    = 25000000,
  parameter int REPEAT_RATE     = 5000000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [3:0]            hex,
  input  logic                  keydown,
  input  logic                  clear,
  output logic                  key_strobe,
  output logic [3:0]            key_code,
  output logic [4*DIGITS-1:0]   value,
  output logic [3:0]            digit_count,
  output logic                  overflow,
  output logic                  key_held
);

  localparam int VW = 4 * DIGITS;
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [3:0] DIG_MAX = 4'(DIGITS);

  if (DIGITS < 1 || DIGITS > 8 || DEBOUNCE_CYCLES < 2 || REPEAT_DELAY < 1 || REPEAT_RATE < 1) begin : g_bad_params
    $error("keypad_hex_entry: parameter out of range");
  end

  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, REL_WAIT} state_t;

  state_t        state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic          kd_m, kd_s;
  logic [3:0]    hex_m, hex_s;
  logic          press_accept, accept;

  // hex travels through the same two stages as keydown so the code matches the level
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      kd_m  <= 1'b0;
      kd_s  <= 1'b0;
      hex_m <= 4'd0;
      hex_s <= 4'd0;
    end else begin
      kd_m  <= keydown;
      kd_s  <= kd_m;
      hex_m <= hex;
      hex_s <= hex_m;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end

  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    press_accept = 1'b0;
    unique case (state)
      IDLE: begin
        if (kd_s) begin
          state_n = PRESS_WAIT;
          cnt_n   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!kd_s) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else if (cnt == DB_LAST) begin
          state_n      = HELD;
          cnt_n        = '0;
          press_accept = 1'b1;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      HELD: begin
        if (!kd_s) begin
          state_n = REL_WAIT;
          cnt_n   = '0;
        end
      end
      REL_WAIT: begin
        if (kd_s) begin
          state_n = HELD;
          cnt_n   = '0;
        end else if (cnt == DB_LAST) begin
          state_n = IDLE;
          cnt_n   = '0;
        end else begin
          cnt_n = cnt + CW'(1);
        end
      end
      default: begin
        state_n = IDLE;
        cnt_n   = '0;
      end
    endcase
  end

`ifdef KEYPAD_HEX_ENTRY_AUTOREPEAT_EN
  localparam int RMAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int RW   = $clog2(RMAX + 1);
  localparam logic [RW-1:0] RD_LAST = RW'(REPEAT_DELAY - 1);
  localparam logic [RW-1:0] RR_LAST = RW'(REPEAT_RATE - 1);

  logic [RW-1:0] rcnt, rcnt_n;
  logic          rphase, rphase_n;
  logic          rep_fire;

  // rcnt only advances while HELD with the key down, so release bounces pause it
  always_comb begin
    rcnt_n   = rcnt;
    rphase_n = rphase;
    rep_fire = 1'b0;
    if (press_accept) begin
      rcnt_n   = '0;
      rphase_n = 1'b0;
    end else if (state == HELD && kd_s) begin
      if (rcnt == (rphase ? RR_LAST : RD_LAST)) begin
        rcnt_n   = '0;
        rphase_n = 1'b1;
        rep_fire = 1'b1;
      end else begin
        rcnt_n = rcnt + RW'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rcnt   <= '0;
      rphase <= 1'b0;
    end else begin
      rcnt   <= rcnt_n;
      rphase <= rphase_n;
    end
  end

  assign accept = press_accept | rep_fire;
`else
  assign accept = press_accept;
`endif

  // clear wins first, then a coincident accept lands on the cleared register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      key_strobe  <= 1'b0;
      key_code    <= 4'd0;
      value       <= '0;
      digit_count <= 4'd0;
      overflow    <= 1'b0;
    end else begin
      key_strobe <= accept;
      if (accept) key_code <= hex_s;
      if (clear) begin
        value       <= accept ? VW'(hex_s) : '0;
        digit_count <= accept ? 4'd1 : 4'd0;
        overflow    <= 1'b0;
      end else if (accept) begin
        value <= (value << 4) | VW'(hex_s);
        if (digit_count < DIG_MAX) digit_count <= digit_count + 4'd1;
        else overflow <= 1'b1;
      end
    end
  end

  assign key_held = (state == HELD) || (state == REL_WAIT);

endmodule
